// File: rtl/divisor_segmentado_param.sv
// Pipelined restoring integer divider: one operation per cycle, per-operation
// signed/unsigned mode, configurable quotient bits per stage, global hold.
module divisor_segmentado_param #(
    parameter int SIZE           = 8,
    parameter int BITS_POR_ETAPA = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_op,
    input  logic            hold,
    input  logic [SIZE-1:0] num,
    input  logic [SIZE-1:0] den,
    output logic [SIZE-1:0] coc,
    output logic [SIZE-1:0] res,
    output logic            done,
    output logic            div0,
    output logic            ovf
);
    localparam int STAGES = SIZE / BITS_POR_ETAPA;
    localparam int LAT    = STAGES + 2;
    localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

    generate
        if (SIZE % BITS_POR_ETAPA != 0) begin : g_bad_split
            $error("SIZE must be a multiple of BITS_POR_ETAPA");
        end
        if (BITS_POR_ETAPA != 1 && BITS_POR_ETAPA != 2 && BITS_POR_ETAPA != 4) begin : g_bad_radix
            $error("BITS_POR_ETAPA must be 1, 2 or 4");
        end
        if (SIZE < 4 || LAT < 3) begin : g_bad_size
            $error("SIZE must be at least 4");
        end
    endgenerate

    // Index 0 is the capture stage, 1..STAGES are the iteration stages.
    logic            valid_q [0:STAGES];
    logic            valid_d [0:STAGES];
    logic [SIZE-1:0] rem_q   [0:STAGES];
    logic [SIZE-1:0] rem_d   [0:STAGES];
    logic [SIZE-1:0] quo_q   [0:STAGES];
    logic [SIZE-1:0] quo_d   [0:STAGES];
    logic [SIZE-1:0] den_q   [0:STAGES];
    logic [SIZE-1:0] den_d   [0:STAGES];
    logic [SIZE-1:0] num_q   [0:STAGES];
    logic [SIZE-1:0] num_d   [0:STAGES];
    logic            qneg_q  [0:STAGES];
    logic            qneg_d  [0:STAGES];
    logic            rneg_q  [0:STAGES];
    logic            rneg_d  [0:STAGES];
    logic            dz_q    [0:STAGES];
    logic            dz_d    [0:STAGES];
    logic            ov_q    [0:STAGES];
    logic            ov_d    [0:STAGES];

    logic [SIZE-1:0] coc_q, coc_d, res_q, res_d;
    logic            done_q, done_d, div0_q, div0_d, ovf_q, ovf_d;

    logic            num_neg, den_neg;
    logic [SIZE-1:0] num_abs, den_abs;

    always_comb begin
        num_neg = signed_op & num[SIZE-1];
        den_neg = signed_op & den[SIZE-1];
        num_abs = num_neg ? -num : num;
        den_abs = den_neg ? -den : den;
    end

    always_comb begin : pipe_comb
        logic [SIZE:0]   r;
        logic [SIZE-1:0] q;
        r = '0;
        q = '0;

        valid_d[0] = start;
        rem_d[0]   = '0;
        quo_d[0]   = num_abs;
        den_d[0]   = den_abs;
        num_d[0]   = num;
        qneg_d[0]  = num_neg ^ den_neg;
        rneg_d[0]  = num_neg;
        dz_d[0]    = (den == '0);
        ov_d[0]    = signed_op && (num == MIN_VAL) && (den == '1);

        for (int s = 1; s <= STAGES; s++) begin
            // The dividend shifts out of q while quotient bits shift in behind it.
            r = {1'b0, rem_q[s-1]};
            q = quo_q[s-1];
            for (int b = 0; b < BITS_POR_ETAPA; b++) begin
                r = {r[SIZE-1:0], q[SIZE-1]};
                q = {q[SIZE-2:0], 1'b0};
                if (r >= {1'b0, den_q[s-1]}) begin
                    r    = r - {1'b0, den_q[s-1]};
                    q[0] = 1'b1;
                end
            end
            valid_d[s] = valid_q[s-1];
            rem_d[s]   = r[SIZE-1:0];
            quo_d[s]   = q;
            den_d[s]   = den_q[s-1];
            num_d[s]   = num_q[s-1];
            qneg_d[s]  = qneg_q[s-1];
            rneg_d[s]  = rneg_q[s-1];
            dz_d[s]    = dz_q[s-1];
            ov_d[s]    = ov_q[s-1];
        end
    end

    always_comb begin
        coc_d  = coc_q;
        res_d  = res_q;
        done_d = 1'b0;
        div0_d = 1'b0;
        ovf_d  = 1'b0;
        if (valid_q[STAGES]) begin
            done_d = 1'b1;
            div0_d = dz_q[STAGES];
            ovf_d  = ov_q[STAGES];
            coc_d  = qneg_q[STAGES] ? -quo_q[STAGES] : quo_q[STAGES];
            res_d  = rneg_q[STAGES] ? -rem_q[STAGES] : rem_q[STAGES];
            if (dz_q[STAGES]) begin
                coc_d = '1;
                res_d = num_q[STAGES];
            end else if (ov_q[STAGES]) begin
                coc_d = MIN_VAL;
                res_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= STAGES; s++) begin
                valid_q[s] <= 1'b0;
                rem_q[s]   <= '0;
                quo_q[s]   <= '0;
                den_q[s]   <= '0;
                num_q[s]   <= '0;
                qneg_q[s]  <= 1'b0;
                rneg_q[s]  <= 1'b0;
                dz_q[s]    <= 1'b0;
                ov_q[s]    <= 1'b0;
            end
            coc_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (!hold) begin
            for (int s = 0; s <= STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                rem_q[s]   <= rem_d[s];
                quo_q[s]   <= quo_d[s];
                den_q[s]   <= den_d[s];
                num_q[s]   <= num_d[s];
                qneg_q[s]  <= qneg_d[s];
                rneg_q[s]  <= rneg_d[s];
                dz_q[s]    <= dz_d[s];
                ov_q[s]    <= ov_d[s];
            end
            coc_q  <= coc_d;
            res_q  <= res_d;
            done_q <= done_d;
            div0_q <= div0_d;
            ovf_q  <= ovf_d;
        end
    end

    assign coc  = coc_q;
    assign res  = res_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_divisor_segmentado_param.sv
// Scoreboard bench: two divider instances (8-bit radix-2, 16-bit 4 bits/stage)
// checked against a plain-arithmetic reference model.
module tb_divisor_segmentado_param;
    localparam int LAT8  = 8 / 1 + 2;
    localparam int LAT16 = 16 / 4 + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        start8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  num8 = '0, den8 = '0, coc8, res8;
    logic        done8, dz8, ov8;
    logic        start16 = 1'b0, sg16 = 1'b0;
    logic [15:0] num16 = '0, den16 = '0, coc16, res16;
    logic        done16, dz16, ov16;

    divisor_segmentado_param #(.SIZE(8), .BITS_POR_ETAPA(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(sg8), .hold(hold),
        .num(num8), .den(den8), .coc(coc8), .res(res8),
        .done(done8), .div0(dz8), .ovf(ov8)
    );

    divisor_segmentado_param #(.SIZE(16), .BITS_POR_ETAPA(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_op(sg16), .hold(hold),
        .num(num16), .den(den16), .coc(coc16), .res(res16),
        .done(done16), .div0(dz16), .ovf(ov16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic [15:0] r;
        bit          z;
        bit          o;
        int          exp_act;
        int          exp_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   act_cnt = 0;
    bit   last_active = 1'b0;
    bit   prev_done8 = 1'b0;
    bit   prev_done16 = 1'b0;

    // Reference: truncating division on signed/unsigned integers, then the special cases.
    function automatic exp_t model(input int w, input bit sg, input longint unsigned n,
                                   input longint unsigned d, input int ea, input int ec);
        exp_t e;
        longint unsigned mask, minv, uc, ur;
        longint sn, sd;
        mask = (64'd1 << w) - 64'd1;
        minv = 64'd1 << (w - 1);
        e.exp_act = ea;
        e.exp_cyc = ec;
        e.z = 1'b0;
        e.o = 1'b0;
        if (d == 0) begin
            uc  = mask;
            ur  = n;
            e.z = 1'b1;
        end else if (!sg) begin
            uc = n / d;
            ur = n % d;
        end else begin
            sn = longint'(n);
            sd = longint'(d);
            if (n >= minv) sn = sn - longint'(mask) - 1;
            if (d >= minv) sd = sd - longint'(mask) - 1;
            uc  = longint'(sn / sd) & mask;
            ur  = longint'(sn % sd) & mask;
            e.o = (n == minv) && (d == mask);
        end
        e.c = uc[15:0];
        e.r = ur[15:0];
        return e;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        last_active <= rst_n && !hold;
        if (rst_n && !hold) act_cnt <= act_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done8 <= 1'b0;
        end else begin
            if (done8 && last_active) begin
                if (q8.size() == 0) begin
                    chk("dut8 unexpected done", done8, 0);
                end else begin
                    chk("dut8 coc", coc8, q8[0].c);
                    chk("dut8 res", res8, q8[0].r);
                    chk("dut8 div0", dz8, q8[0].z);
                    chk("dut8 ovf", ov8, q8[0].o);
                    chk("dut8 active-cycle latency", act_cnt, q8[0].exp_act);
                    if (q8[0].exp_cyc >= 0) chk("dut8 wall latency", cyc, q8[0].exp_cyc);
                    q8.delete(0);
                end
            end else if (!last_active && prev_done8) begin
                chk("dut8 done held during hold", done8, 1);
            end
            if (q8.size() > 0 && q8[0].exp_act < act_cnt) begin
                chk("dut8 missing done", act_cnt, q8[0].exp_act);
                q8.delete(0);
            end
            prev_done8 <= done8;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done16 <= 1'b0;
        end else begin
            if (done16 && last_active) begin
                if (q16.size() == 0) begin
                    chk("dut16 unexpected done", done16, 0);
                end else begin
                    chk("dut16 coc", coc16, q16[0].c);
                    chk("dut16 res", res16, q16[0].r);
                    chk("dut16 div0", dz16, q16[0].z);
                    chk("dut16 ovf", ov16, q16[0].o);
                    chk("dut16 active-cycle latency", act_cnt, q16[0].exp_act);
                    if (q16[0].exp_cyc >= 0) chk("dut16 wall latency", cyc, q16[0].exp_cyc);
                    q16.delete(0);
                end
            end else if (!last_active && prev_done16) begin
                chk("dut16 done held during hold", done16, 1);
            end
            if (q16.size() > 0 && q16[0].exp_act < act_cnt) begin
                chk("dut16 missing done", act_cnt, q16[0].exp_act);
                q16.delete(0);
            end
            prev_done16 <= done16;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1 with hold=0; extra = held cycles expected before done.
    task automatic op8(input bit sg, input logic [7:0] n, input logic [7:0] d, input int extra);
        start8 = 1'b1; sg8 = sg; num8 = n; den8 = d;
        q8.push_back(model(8, sg, n, d, act_cnt + LAT8, cyc + LAT8 + extra));
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    task automatic op16(input bit sg, input logic [15:0] n, input logic [15:0] d, input int extra);
        start16 = 1'b1; sg16 = sg; num16 = n; den16 = d;
        q16.push_back(model(16, sg, n, d, act_cnt + LAT16, cyc + LAT16 + extra));
        @(posedge clk);
        #1;
        start16 = 1'b0;
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, " coc8"}, coc8, 0);
        chk({nm, " res8"}, res8, 0);
        chk({nm, " done8"}, done8, 0);
        chk({nm, " div0_8"}, dz8, 0);
        chk({nm, " ovf8"}, ov8, 0);
        chk({nm, " coc16"}, coc16, 0);
        chk({nm, " done16"}, done16, 0);
    endtask

    initial begin
        #3;
        check_zero_outputs("reset state");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed operands from the plan, issued back to back.
        op8(1'b0, 8'd100, 8'd7, 0);
        op8(1'b1, 8'hF9, 8'h02, 0);
        op8(1'b0, 8'hF9, 8'h02, 0);
        op8(1'b0, 8'd55, 8'd0, 0);
        op8(1'b1, 8'd55, 8'd0, 0);
        op8(1'b1, 8'h80, 8'hFF, 0);
        op16(1'b1, 16'h8000, 16'hFFFF, 0);
        op16(1'b0, 16'd50000, 16'd0, 0);
        idle(LAT8 + 3);

        // Hold for two cycles while three ops are in flight; start during hold is ignored.
        op8(1'b0, 8'd200, 8'd3, 2);
        op8(1'b0, 8'd17, 8'd17, 2);
        op8(1'b0, 8'd5, 8'd9, 2);
        idle(2);
        hold = 1'b1; start8 = 1'b1; num8 = 8'd99; den8 = 8'd4;
        idle(2);
        hold = 1'b0; start8 = 1'b0;
        idle(LAT8 + 3);

        // Hold raised while done is high: the pulse must stretch.
        op8(1'b0, 8'd200, 8'd7, 0);
        idle(LAT8 - 1);
        hold = 1'b1; start8 = 1'b1; num8 = 8'd42; den8 = 8'd5;
        idle(2);
        hold = 1'b0; start8 = 1'b0;
        idle(LAT8 + 3);

        // Async reset mid-flight discards everything in the pipeline.
        op8(1'b0, 8'd90, 8'd4, 0);
        op8(1'b1, 8'hC8, 8'd3, 0);
        op8(1'b0, 8'd11, 8'd2, 0);
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        check_zero_outputs("async reset");
        q8.delete();
        q16.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        op8(1'b0, 8'd77, 8'd5, 0);
        idle(LAT8 + 3);

        // Random sweep on both instances with occasional hold.
        for (int i = 0; i < 10000; i++) begin
            hold   = ($urandom_range(0, 15) == 0);
            start8 = ($urandom_range(0, 3) != 0);
            sg8    = 1'($urandom_range(0, 1));
            num8   = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       den8 = 8'h00;
                1:       den8 = 8'hFF;
                2:       den8 = 8'($urandom_range(1, 3));
                default: den8 = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) num8 = 8'h80;
            start16 = ($urandom_range(0, 3) != 0);
            sg16    = 1'($urandom_range(0, 1));
            num16   = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       den16 = 16'h0000;
                1:       den16 = 16'hFFFF;
                2:       den16 = 16'($urandom_range(1, 300));
                default: den16 = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) num16 = 16'h8000;
            if (!hold && start8)
                q8.push_back(model(8, sg8, num8, den8, act_cnt + LAT8, -1));
            if (!hold && start16)
                q16.push_back(model(16, sg16, num16, den16, act_cnt + LAT16, -1));
            @(posedge clk);
            #1;
        end
        hold = 1'b0; start8 = 1'b0; start16 = 1'b0;
        idle(LAT8 + 5);

        chk("dut8 scoreboard drained", q8.size(), 0);
        chk("dut16 scoreboard drained", q16.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before 2000000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/divisor_segmentado_param.md
Name: divisor_segmentado_param

Overview:
- Parametrised, fully pipelined integer divider; next generation of the 8-bit pipelined divider.
- Accepts one operation per cycle and supports a per-operation signed/unsigned mode.
- Configurable radix (bits resolved per stage), a pipeline hold, and divide-by-zero and overflow flags.
- Sits behind the test_if-style bus wrapper; the existing stimulus/monitor bench drives it directly.

Parameters:
- SIZE, 8, operand/result width in bits (≥4).
- BITS_POR_ETAPA, 1, quotient bits resolved per iteration stage; legal values 1, 2, 4; must divide SIZE.
- STAGES, SIZE/BITS_POR_ETAPA, derived (localparam), number of iteration stages.
- LAT, STAGES+2, derived (localparam), cycles from accepted start to done.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation valid; sampled on a clk edge when hold=0.
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned.
- hold  in  1  freeze whole pipeline (all stage registers and outputs keep their values).
- num  in  SIZE  dividend.
- den  in  SIZE  divisor.
- coc  out  SIZE  quotient.
- res  out  SIZE  remainder.
- done  out  1  result valid; one-cycle pulse per operation (held while hold=1).
- div0  out  1  qualifies done: divisor was zero.
- ovf  out  1  qualifies done: signed overflow (MIN / -1).

Behaviour:
- Reset (async, rst_n=0): every stage valid bit cleared; coc=0, res=0, done=0, div0=0, ovf=0. Release is synchronous to clk. In-flight operations are discarded and never produce done.
- Pipeline structure:
  - Stage 0 (capture): registers valid=start, mode, |num|, |den|, the sign of the quotient (num_msb^den_msb) and the sign of the remainder (num_msb). Absolute values are taken only when signed_op=1. Flags div0 (den==0) and ovf (signed, num==MIN, den==all-ones) are computed here and travel with the operation.
  - Stages 1..STAGES: restoring division, BITS_POR_ETAPA quotient bits per stage. Partial remainder width is SIZE+1. Each stage carries its own copy of the divisor and flags.
  - Output stage: applies sign correction, special-case override and flags, then registers coc/res/done/div0/ovf.
- Latency: start sampled at edge k with hold=0 → done=1 in the cycle following edge k+LAT-1. Throughput is one op/cycle; results leave in issue order.
- Sign rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - num = coc*den + res holds mod 2^SIZE in all non-div0 cases.
- Special cases (override the arithmetic result):
  - den==0: coc = all ones, res = num (original, unmodified), div0=1, ovf=0. Applies in both modes.
  - Signed MIN / -1: coc = MIN, res = 0, ovf=1, div0=0.
- hold:
  - While hold=1, no register updates and start is ignored (not captured).
  - done/coc/res keep their values, so a done pulse present when hold rises stays high until the first cycle after hold falls.
  - hold does not affect reset.
- done=0 cycles: coc/res keep their last values; the bench must check them only when done=1.
- start=1 with hold=0 on consecutive edges: each accepted and completed independently.
- Simultaneous start and a done emerging: no interaction.
- Synthesis must fail (elaboration assertion) if SIZE % BITS_POR_ETAPA != 0.

Test Plan:
- SIZE=8, BITS_POR_ETAPA=1, unsigned 100/7 → coc=14, res=2, div0=0, ovf=0; done exactly LAT=10 cycles after start.
- Signed 8'hF9(-7) / 8'h02 → coc=8'hFD(-3), res=8'hFF(-1); same operands unsigned (249/2) → coc=124, res=1.
- 55/0 in each mode → coc=8'hFF, res=8'h37, div0=1; signed 8'h80 / 8'hFF → coc=8'h80, res=8'h00, ovf=1.
- Back-to-back ops 200/3, 17/17, 5/9 on three consecutive edges, hold=1 for 2 cycles mid-flight:
  - Results 66r2, 1r0, 0r5 come out in order.
  - Total latency is stretched by exactly 2 cycles.
  - done stays high across a hold.
  - start asserted during hold is not captured.
- rst_n pulsed low for 1 cycle 4 cycles after issuing 3 ops → outputs zero immediately (async); no done ever appears for those ops; a new op after release completes normally.
- SIZE=16, BITS_POR_ETAPA=4 (LAT=6): random signed/unsigned sweep of 10k ops against a reference model; plus 16'h8000 / 16'hFFFF → ovf=1, coc=16'h8000.
